equiv_vec_sequencer: RTL and testbench

- Sequences stimulus vectors from a vector ROM into two instances of a generated `top`: the reference netlist and the synthesized netlist.
- Waits a programmable settle time after each vector, then compares the wide `y` buses of the two instances.
- Accumulates a mismatch count and the first failing vector index.
- Replaces free-running timed stimulus with a start/done-controlled run, for equivalence regression on simulation farms.

---
 rtl/equiv_seq_pkg.sv | 42 ++++
 rtl/equiv_vec_sequencer.sv | 163 ++++++++++++++++
 tb/tb_equiv_vec_sequencer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/equiv_seq_pkg.sv
// Shared types and constants for the equivalence vector sequencer.
package equiv_seq_pkg;

  localparam int unsigned STIM_W_DEF = 45;
  localparam int unsigned Y_W_DEF    = 754;

  // Field layout of the concatenated stimulus {wire3, wire2, wire1, wire0}
  localparam int unsigned WIRE0_OFS = 0;
  localparam int unsigned WIRE0_W   = 16;
  localparam int unsigned WIRE1_OFS = 16;
  localparam int unsigned WIRE1_W   = 10;
  localparam int unsigned WIRE2_OFS = 26;
  localparam int unsigned WIRE2_W   = 6;
  localparam int unsigned WIRE3_OFS = 32;
  localparam int unsigned WIRE3_W   = 13;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_WAIT  = 3'd3,
    S_CHECK = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  // Assemble a stimulus word from its four input buses
  function automatic logic [STIM_W_DEF-1:0] pack_stim(
    input logic [WIRE0_W-1:0] w0,
    input logic [WIRE1_W-1:0] w1,
    input logic [WIRE2_W-1:0] w2,
    input logic [WIRE3_W-1:0] w3
  );
    logic [STIM_W_DEF-1:0] s;
    s = '0;
    s[WIRE0_OFS +: WIRE0_W] = w0;
    s[WIRE1_OFS +: WIRE1_W] = w1;
    s[WIRE2_OFS +: WIRE2_W] = w2;
    s[WIRE3_OFS +: WIRE3_W] = w3;
    return s;
  endfunction

endpackage

// File: rtl/equiv_vec_sequencer.sv
// Start/done controlled vector sequencer comparing reference and synthesized netlist outputs.
module equiv_vec_sequencer
  import equiv_seq_pkg::*;
#(
  parameter int unsigned STIM_W  = STIM_W_DEF,
  parameter int unsigned Y_W     = Y_W_DEF,
  parameter int unsigned NUM_VEC = 20,
  parameter int unsigned SETTLE  = 1,
  parameter int unsigned IDX_W   = 8,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              rom_rd,
  output logic [IDX_W-1:0]  rom_addr,
  input  logic [STIM_W-1:0] rom_data,
  output logic [STIM_W-1:0] stim,
  input  logic [Y_W-1:0]    y_ref,
  input  logic [Y_W-1:0]    y_dut,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic [IDX_W-1:0]  first_fail_idx,
  output logic              first_fail_valid,
  output logic              pass
);

  localparam int unsigned       SCNT_W    = 8;
  localparam logic [SCNT_W-1:0] SETTLE_M1 = SCNT_W'(SETTLE - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_VEC);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [SCNT_W-1:0]   scnt_q, scnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                rom_rd_q, rom_rd_d;
  logic [IDX_W-1:0]    rom_addr_q, rom_addr_d;
  logic [STIM_W-1:0]   stim_q, stim_d;
  logic [CNT_W-1:0]    mcnt_q, mcnt_d;
  logic [IDX_W-1:0]    ffi_q, ffi_d;
  logic                ffv_q, ffv_d;
  logic                pass_q, pass_d;
  logic                differ_c;

  assign differ_c = (y_ref != y_dut);

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      scnt_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rom_rd_q   <= 1'b0;
      rom_addr_q <= '0;
      stim_q     <= '0;
      mcnt_q     <= '0;
      ffi_q      <= '0;
      ffv_q      <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      scnt_q     <= scnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rom_rd_q   <= rom_rd_d;
      rom_addr_q <= rom_addr_d;
      stim_q     <= stim_d;
      mcnt_q     <= mcnt_d;
      ffi_q      <= ffi_d;
      ffv_q      <= ffv_d;
      pass_q     <= pass_d;
    end
  end

  // Next-state selection; abort overrides everything but reset
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: if (start) state_d = S_WAIT;
        S_FETCH:        state_d = S_LOAD;
        S_LOAD:         state_d = S_WAIT;
        S_WAIT:         if (scnt_q == '0) state_d = S_CHECK;
        S_CHECK:        state_d = (idx_q == LAST_IDX) ? S_DONE : S_FETCH;
        default:        state_d = S_IDLE;
      endcase
    end
  end

  // Datapath and registered output updates
  always_comb begin
    idx_d      = idx_q;
    scnt_d     = scnt_q;
    rom_addr_d = rom_addr_q;
    stim_d     = stim_q;
    mcnt_d     = mcnt_q;
    ffi_d      = ffi_q;
    ffv_d      = ffv_q;
    rom_rd_d   = 1'b0;
    busy_d     = !((state_d == S_IDLE) || (state_d == S_DONE));
    // done follows one cycle after DONE is entered and drops on leaving it
    done_d     = (state_q == S_DONE) && (state_d == S_DONE);
    pass_d     = done_d && (mcnt_q == '0);

    if (!abort) begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            mcnt_d = '0;
            ffi_d  = '0;
            ffv_d  = 1'b0;
            stim_d = '0;
            idx_d  = '0;
            scnt_d = SETTLE_M1;
          end
        end
        S_LOAD: begin
          stim_d = rom_data;
          scnt_d = SETTLE_M1;
        end
        S_WAIT: begin
          if (scnt_q != '0) scnt_d = scnt_q - SCNT_W'(1);
        end
        S_CHECK: begin
          if (differ_c) begin
            if (mcnt_q != CNT_MAX) mcnt_d = mcnt_q + CNT_W'(1);
            if (!ffv_q) begin
              ffi_d = idx_q;
              ffv_d = 1'b1;
            end
          end
          if (idx_q != LAST_IDX) begin
            // Vector idx lives at ROM address idx-1 (index 0 is the zero vector)
            idx_d      = idx_q + IDX_W'(1);
            rom_rd_d   = 1'b1;
            rom_addr_d = idx_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign rom_rd           = rom_rd_q;
  assign rom_addr         = rom_addr_q;
  assign stim             = stim_q;
  assign mismatch_cnt     = mcnt_q;
  assign first_fail_idx   = ffi_q;
  assign first_fail_valid = ffv_q;
  assign pass             = pass_q;

endmodule

// File: tb/tb_equiv_vec_sequencer.sv
// Self-checking bench: short run against a random ROM plus a long saturating run.
module tb_equiv_vec_sequencer;
  import equiv_seq_pkg::*;

  localparam int unsigned SW    = 45;
  localparam int unsigned YW    = 754;
  localparam int unsigned NV_A  = 4;
  localparam int unsigned ST_A  = 1;
  localparam int unsigned NV_B  = 300;
  localparam int unsigned ST_B  = 2;
  localparam int          LAT_A = (1 + ST_A) + NV_A * (3 + ST_A) + 1;
  localparam int          LAT_B = (1 + ST_B) + NV_B * (3 + ST_B) + 1;
  localparam logic [YW-1:0] MSB_MASK = {1'b1, {(YW-1){1'b0}}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          start_a = 1'b0, abort_a = 1'b0;
  logic          busy_a, done_a, rom_rd_a, ffv_a, pass_a;
  logic [7:0]    rom_addr_a, mcnt_a, ffi_a;
  logic [SW-1:0] rom_data_a = '0, stim_a;
  logic [YW-1:0] y_ref_a, y_dut_a;

  logic          start_b = 1'b0, abort_b = 1'b0;
  logic          busy_b, done_b, rom_rd_b, ffv_b, pass_b;
  logic [8:0]    rom_addr_b, ffi_b;
  logic [7:0]    mcnt_b;
  logic [SW-1:0] rom_data_b = '0, stim_b;
  logic [YW-1:0] y_ref_b, y_dut_b;

  logic [SW-1:0] rom_a [0:255];
  logic [7:0]    rd_log [$];
  logic          fault_en = 1'b0;
  logic [SW-1:0] fault_vec = '0;

  int n_assert = 0;
  int n_fail   = 0;

  equiv_vec_sequencer #(.STIM_W(SW), .Y_W(YW), .NUM_VEC(NV_A), .SETTLE(ST_A),
                        .IDX_W(8), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
    .busy(busy_a), .done(done_a), .rom_rd(rom_rd_a), .rom_addr(rom_addr_a),
    .rom_data(rom_data_a), .stim(stim_a), .y_ref(y_ref_a), .y_dut(y_dut_a),
    .mismatch_cnt(mcnt_a), .first_fail_idx(ffi_a), .first_fail_valid(ffv_a),
    .pass(pass_a)
  );

  equiv_vec_sequencer #(.STIM_W(SW), .Y_W(YW), .NUM_VEC(NV_B), .SETTLE(ST_B),
                        .IDX_W(9), .CNT_W(8)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
    .busy(busy_b), .done(done_b), .rom_rd(rom_rd_b), .rom_addr(rom_addr_b),
    .rom_data(rom_data_b), .stim(stim_b), .y_ref(y_ref_b), .y_dut(y_dut_b),
    .mismatch_cnt(mcnt_b), .first_fail_idx(ffi_b), .first_fail_valid(ffv_b),
    .pass(pass_b)
  );

  // Stand-in for the generated netlist: a fixed scramble of the stimulus
  function automatic logic [YW-1:0] top_model(input logic [SW-1:0] s);
    logic [YW-1:0] r;
    for (int i = 0; i < int'(YW); i++)
      r[i] = s[(i * 7) % 45] ^ s[(i * 13 + 3) % 45] ^ ((i % 3) == 0);
    return r;
  endfunction

  always_comb begin
    y_ref_a = top_model(stim_a);
    y_dut_a = y_ref_a ^ ((fault_en && (stim_a == fault_vec)) ? MSB_MASK : '0);
    y_ref_b = top_model(stim_b);
    y_dut_b = ~y_ref_b;
  end

  // Synchronous ROMs with one-cycle read latency, plus read-address log
  always @(posedge clk) begin
    if (rom_rd_a) begin
      rom_data_a <= rom_a[rom_addr_a];
      rd_log.push_back(rom_addr_a);
    end
    if (rom_rd_b) rom_data_b <= {36'(rom_addr_b) * 36'd977, rom_addr_b};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_a();
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_done", 64'(done_a), 64'd0);
    chk("rst_rom_rd", 64'(rom_rd_a), 64'd0);
    chk("rst_rom_addr", 64'(rom_addr_a), 64'd0);
    chk("rst_stim", 64'(stim_a), 64'd0);
    chk("rst_mcnt", 64'(mcnt_a), 64'd0);
    chk("rst_ffi", 64'(ffi_a), 64'd0);
    chk("rst_ffv", 64'(ffv_a), 64'd0);
    chk("rst_pass", 64'(pass_a), 64'd0);
  endtask

  // Start a run on instance A, optionally pulsing start again mid-run
  task automatic run_a(input int restart_at);
    int lat;
    rd_log.delete();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("start_done_drop", 64'(done_a), 64'd0);
    chk("start_busy", 64'(busy_a), 64'd1);
    chk("start_stim_zero", 64'(stim_a), 64'd0);
    chk("start_mcnt_clr", 64'(mcnt_a), 64'd0);
    chk("start_ffv_clr", 64'(ffv_a), 64'd0);
    lat = 0;
    while (!done_a && lat < 400) begin
      start_a = (lat == restart_at);
      tick();
      start_a = 1'b0;
      lat++;
    end
    chk("latency_a", 64'(lat), 64'(LAT_A));
  endtask

  // Compare end-of-run results against the vector-list model
  task automatic expect_results_a(input string tag);
    int            exp_cnt;
    int            exp_ffi;
    logic          exp_ffv;
    logic [SW-1:0] v;
    exp_cnt = 0;
    exp_ffi = 0;
    exp_ffv = 1'b0;
    for (int i = 0; i <= int'(NV_A); i++) begin
      v = (i == 0) ? '0 : rom_a[i-1];
      if (fault_en && (v == fault_vec)) begin
        if (!exp_ffv) begin
          exp_ffv = 1'b1;
          exp_ffi = i;
        end
        if (exp_cnt < 255) exp_cnt++;
      end
    end
    chk({tag, "_mcnt"}, 64'(mcnt_a), 64'(exp_cnt));
    chk({tag, "_ffi"}, 64'(ffi_a), 64'(exp_ffi));
    chk({tag, "_ffv"}, 64'(ffv_a), 64'(exp_ffv));
    chk({tag, "_pass"}, 64'(pass_a), 64'(exp_cnt == 0));
    chk({tag, "_busy"}, 64'(busy_a), 64'd0);
    chk({tag, "_stim_last"}, 64'(stim_a), 64'(rom_a[NV_A-1]));
    chk({tag, "_rd_count"}, 64'(rd_log.size()), 64'(NV_A));
    for (int i = 0; i < rd_log.size(); i++)
      chk({tag, "_rd_addr"}, 64'(rd_log[i]), 64'(i));
  endtask

  initial begin
    int lat_b;
    int k;
    for (int i = 0; i < 256; i++)
      rom_a[i] = pack_stim(16'($urandom), 10'($urandom), 6'($urandom), 13'($urandom)) | 45'd1;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    chk_reset_a();
    chk("rst_b_busy", 64'(busy_b), 64'd0);
    chk("rst_b_done", 64'(done_b), 64'd0);
    rst = 1'b0;
    tick();

    // Clean run
    fault_en = 1'b0;
    run_a(-1);
    expect_results_a("clean");

    // Single fault while vector index 2 (ROM[1]) is applied
    fault_en  = 1'b1;
    fault_vec = rom_a[1];
    run_a(-1);
    expect_results_a("fault1");

    // Start while in DONE repeats the same run
    run_a(-1);
    expect_results_a("repeat");

    // Start pulsed while busy has no effect
    fault_en = 1'b0;
    run_a(5);
    expect_results_a("busy_start");

    // Random fault target
    k = int'($urandom_range(0, NV_A - 1));
    fault_en  = 1'b1;
    fault_vec = rom_a[k];
    run_a(-1);
    expect_results_a("rand_fault");

    // Abort seven cycles into a run; results so far stay frozen
    fault_vec = rom_a[0];
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (6) tick();
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    chk("abort_busy", 64'(busy_a), 64'd0);
    chk("abort_done", 64'(done_a), 64'd0);
    chk("abort_mcnt", 64'(mcnt_a), 64'd1);
    chk("abort_ffi", 64'(ffi_a), 64'd1);
    chk("abort_ffv", 64'(ffv_a), 64'd1);
    repeat (3) tick();
    chk("abort_idle", 64'(busy_a), 64'd0);
    abort_a = 1'b1;
    start_a = 1'b1;
    tick();
    abort_a = 1'b0;
    start_a = 1'b0;
    chk("abort_beats_start", 64'(busy_a), 64'd0);
    run_a(-1);
    expect_results_a("after_abort");

    // Reset in WAIT with start high
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("pre_rst_busy", 64'(busy_a), 64'd1);
    rst = 1'b1;
    start_a = 1'b1;
    tick();
    rst = 1'b0;
    start_a = 1'b0;
    chk_reset_a();
    repeat (4) tick();
    chk("post_rst_idle_busy", 64'(busy_a), 64'd0);
    chk("post_rst_idle_done", 64'(done_a), 64'd0);

    // Long run with every compare failing: counter saturates
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    lat_b = 0;
    while (!done_b && lat_b < 3000) begin
      tick();
      lat_b++;
    end
    chk("b_latency", 64'(lat_b), 64'(LAT_B));
    chk("b_mcnt_sat", 64'(mcnt_b), 64'd255);
    chk("b_ffi", 64'(ffi_b), 64'd0);
    chk("b_ffv", 64'(ffv_b), 64'd1);
    chk("b_pass", 64'(pass_b), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
